// File: rtl/wb_fifo_pkg.sv
// wb_fifo_pkg: state encoding and status-word decoding shared by the FIFO block drainer.
package wb_fifo_pkg;

    typedef enum logic [2:0] {S_IDLE, S_POLL, S_EVAL, S_READ, S_PUSH, S_WAIT, S_FIN} state_t;

    localparam int STAT_EMPTY_BIT = 0;

    // An asserted empty flag overrides the level field, so a stale level can never trigger a read.
    function automatic logic [31:0] stat_level(input logic [31:0] dat, input int adr_w);
        logic [31:0] w_mask;
        w_mask = (32'd1 << (adr_w + 1)) - 32'd1;
        return dat[STAT_EMPTY_BIT] ? 32'd0 : ((dat >> 1) & w_mask);
    endfunction

endpackage

// File: rtl/wb_fifo_block_drainer_rd.sv
// wb_single_rd_master: one Wishbone single read; registered cyc/stb held until ack, dropped on the ack edge.
module wb_single_rd_master (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        done_o,
    output logic [31:0] dat_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i
);

    logic r_stb;

    // The ack branch wins over req_i so the strobe always sees at least one low cycle between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_stb <= 1'b0;
        else if (r_stb && ack_i) r_stb <= 1'b0;
        else if (req_i) r_stb <= 1'b1;
    end

    assign cyc_o  = r_stb;
    assign stb_o  = r_stb;
    assign done_o = r_stb && ack_i;
    assign dat_o  = dat_i;

endmodule

// File: rtl/wb_fifo_block_drainer.sv
// wb_fifo_block_drainer: polls a FIFO reader's fill level, then reads and streams a fixed-length block of words.
module wb_fifo_block_drainer
    import wb_fifo_pkg::*;
#(
    parameter int ADR_W    = 4,
    parameter int LEN_W    = 16,
    parameter int POLL_GAP = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wbs_cyc_o,
    output logic             wbs_stb_o,
    input  logic             wbs_ack_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbd_cyc_o,
    output logic             wbd_stb_o,
    input  logic             wbd_ack_i,
    input  logic [31:0]      wbd_dat_i,
    output logic [31:0]      out_dat_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i
);

    localparam int GW = $clog2(POLL_GAP) + 1;

    state_t           r_state, w_next;
    logic [LEN_W-1:0] r_rem;
    logic [ADR_W:0]   r_lvl, r_burst, w_burst, w_s_lvl;
    logic [GW-1:0]    r_wait;
    logic [31:0]      r_out_dat, w_s_dat, w_d_dat;
    logic             r_out_vld, r_abt, w_abt, w_acc;
    logic             w_s_req, w_d_req, w_s_done, w_d_done;

    assign w_s_req = r_state == S_POLL;
    assign w_d_req = r_state == S_READ;
    assign w_abt   = abort_i || r_abt;
    assign w_acc   = r_out_vld && out_rdy_i;
    assign w_s_lvl = (ADR_W+1)'(stat_level(w_s_dat, ADR_W));
    // Compare at block-length width; the min always fits the level width.
    assign w_burst = (LEN_W'(r_lvl) < r_rem) ? r_lvl : r_rem[ADR_W:0];

    wb_single_rd_master u_stat (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (w_s_req),
        .done_o (w_s_done),
        .dat_o  (w_s_dat),
        .cyc_o  (wbs_cyc_o),
        .stb_o  (wbs_stb_o),
        .ack_i  (wbs_ack_i),
        .dat_i  (wbs_dat_i)
    );

    wb_single_rd_master u_data (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (w_d_req),
        .done_o (w_d_done),
        .dat_o  (w_d_dat),
        .cyc_o  (wbd_cyc_o),
        .stb_o  (wbd_stb_o),
        .ack_i  (wbd_ack_i),
        .dat_i  (wbd_dat_i)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i && !abort_i) w_next = (len_i == '0) ? S_FIN : S_POLL;
            S_POLL:  if (w_s_done) w_next = w_abt ? S_IDLE : S_EVAL;
            S_EVAL:  w_next = abort_i ? S_IDLE : (r_lvl == '0) ? S_WAIT : S_READ;
            S_READ:  if (w_d_done) w_next = w_abt ? S_IDLE : S_PUSH;
            S_PUSH:  if (abort_i) w_next = S_IDLE;
                     else if (w_acc) w_next = (r_rem == LEN_W'(1)) ? S_FIN :
                                              (r_burst == (ADR_W+1)'(1)) ? S_POLL : S_READ;
            S_WAIT:  w_next = abort_i ? S_IDLE : (r_wait == '0) ? S_POLL : S_WAIT;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_lvl     <= '0;
            r_burst   <= '0;
            r_wait    <= '0;
            r_abt     <= 1'b0;
            r_out_dat <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_state <= w_next;
            // Remembers an abort seen while a bus cycle is still waiting for its ack.
            r_abt   <= w_abt && (w_next == S_POLL || w_next == S_READ);
            if (r_state == S_IDLE) r_rem <= len_i;
            else if (r_state == S_PUSH && w_acc) r_rem <= r_rem - 1'b1;
            if (w_s_done) r_lvl <= w_s_lvl;
            if (r_state == S_EVAL) r_burst <= w_burst;
            else if (r_state == S_PUSH && w_acc) r_burst <= r_burst - 1'b1;
            if (r_state == S_EVAL) r_wait <= GW'(POLL_GAP - 1);
            else if (r_wait != '0) r_wait <= r_wait - 1'b1;
            if (r_state == S_READ && w_d_done && !w_abt) r_out_dat <= w_d_dat;
            r_out_vld <= (r_state == S_READ && w_d_done && !w_abt) || (r_out_vld && !w_acc && !abort_i);
        end
    end

    assign busy_o    = r_state != S_IDLE && r_state != S_FIN;
    assign done_o    = r_state == S_FIN;
    assign out_dat_o = r_out_dat;
    assign out_vld_o = r_out_vld;

endmodule

// File: tb/tb_wb_fifo_block_drainer.sv
// tb_wb_fifo_block_drainer: table-driven block drains against a FIFO slave model, plus stall/abort/reset sequences.
module tb_wb_fifo_block_drainer;

    localparam int ADR_W = 4, LEN_W = 16, POLL_GAP = 4;

    logic clk = 1'b0;
    logic rst_i, start_i, abort_i, out_rdy_i, wbs_ack_i, wbd_ack_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0] wbs_dat_i, wbd_dat_i, out_dat_o;
    logic busy_o, done_o, wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o, out_vld_o;

    always #5 clk = ~clk;

    wb_fifo_block_drainer #(.ADR_W(ADR_W), .LEN_W(LEN_W), .POLL_GAP(POLL_GAP)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
        .wbd_cyc_o(wbd_cyc_o), .wbd_stb_o(wbd_stb_o), .wbd_ack_i(wbd_ack_i), .wbd_dat_i(wbd_dat_i),
        .out_dat_o(out_dat_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i)
    );

    // FIFO slave model: level, data sequence, optional empty polls and one refill when drained.
    int lvl, pend, refill, empty_left, n_polls, n_reads, gap_bad, overread, cyc_cnt, last_poll;
    logic [31:0] next_word;
    int cfg_fill, cfg_empty, cfg_refill;
    logic [31:0] cfg_base;
    logic cfg_load, s_ack_en, d_ack_en;

    assign wbs_ack_i = wbs_stb_o && s_ack_en;
    assign wbd_ack_i = wbd_stb_o && d_ack_en;
    assign wbs_dat_i = {26'd0, lvl[4:0], lvl == 0};
    assign wbd_dat_i = next_word;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (cfg_load) begin
            lvl        <= (cfg_empty > 0) ? 0 : cfg_fill;
            pend       <= cfg_fill;
            empty_left <= cfg_empty;
            refill     <= cfg_refill;
            next_word  <= cfg_base;
            n_polls    <= 0;
            n_reads    <= 0;
            gap_bad    <= 0;
        end else begin
            if (wbs_stb_o && wbs_ack_i) begin
                n_polls   <= n_polls + 1;
                last_poll <= cyc_cnt;
                if (n_polls != 0 && cyc_cnt - last_poll != POLL_GAP + 3) gap_bad <= gap_bad + 1;
                if (lvl == 0 && empty_left > 0) begin
                    empty_left <= empty_left - 1;
                    if (empty_left == 1) lvl <= pend;
                end
            end
            if (wbd_stb_o && wbd_ack_i) begin
                n_reads   <= n_reads + 1;
                next_word <= next_word + 32'd1;
                if (lvl == 0) overread <= overread + 1;
                else if (lvl == 1 && refill != 0) begin
                    lvl    <= refill;
                    refill <= 0;
                end else lvl <= lvl - 1;
            end
        end
    end

    logic [31:0] exp_q[$];
    int checks, failures, n_acc, vld_cnt, done_cnt, ovl_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock: monitor/scoreboard at the falling edge, then return just after the rising edge.
    task automatic cyc1();
        logic [31:0] e;
        @(negedge clk);
        if (wbs_stb_o && wbd_stb_o) ovl_cnt++;
        if (out_vld_o) vld_cnt++;
        if (done_o) done_cnt++;
        if (out_vld_o && out_rdy_i && !rst_i) begin
            n_acc++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got %0h required no word", out_dat_o);
            end else begin
                e = exp_q.pop_front();
                if (out_dat_o !== e) begin
                    failures++;
                    $display("FAIL sb_word: got %0h required %0h", out_dat_o, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int fill, input int empty, input int rf, input logic [31:0] base);
        cfg_fill = fill; cfg_empty = empty; cfg_refill = rf; cfg_base = base;
        cfg_load = 1'b1;
        cyc1();
        cfg_load = 1'b0;
    endtask

    task automatic start_blk(input int len);
        len_i = LEN_W'(len);
        start_i = 1'b1;
        cyc1();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_o && cyc < 4000) begin
            cyc1();
            cyc++;
        end
        cyc1();
    endtask

    typedef struct {
        int len; int fill; int empty; int refill;
        int exp_polls; int exp_reads; int exp_cyc; bit chk_gap;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int c, d0, a0, v0, bad;
        logic [31:0] hold, base;
        vecs[0] = '{8,  16, 0, 0,  1, 8,  28, 1'b1};
        vecs[1] = '{20, 16, 0, 16, 2, 20, 0,  1'b0};
        vecs[2] = '{5,  3,  0, 2,  2, 5,  0,  1'b0};
        vecs[3] = '{4,  6,  3, 0,  4, 4,  0,  1'b1};
        vecs[4] = '{1,  1,  0, 0,  1, 1,  7,  1'b1};
        vecs[5] = '{0,  0,  0, 0,  0, 0,  1,  1'b1};
        vecs[6] = '{16, 16, 0, 0,  1, 16, 52, 1'b1};
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; out_rdy_i = 1'b1; len_i = '0;
        s_ack_en = 1'b1; d_ack_en = 1'b1; cfg_load = 1'b0;
        cfg_fill = 0; cfg_empty = 0; cfg_refill = 0; cfg_base = '0;
        repeat (3) cyc1();
        chk("reset_ctrl", {busy_o, done_o, wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o, out_vld_o}, 0);
        chk("reset_data", out_dat_o, 0);
        rst_i = 1'b0;
        cyc1();

        for (int i = 0; i < 7; i++) begin
            base = 32'hA000_0000 + 32'(i << 8);
            load_cfg(vecs[i].fill, vecs[i].empty, vecs[i].refill, base);
            for (int k = 0; k < vecs[i].len; k++) exp_q.push_back(base + 32'(k));
            d0 = done_cnt;
            start_blk(vecs[i].len);
            wait_done(c);
            chk($sformatf("v%0d_done_in_time", i), c < 4000, 1);
            if (vecs[i].exp_cyc != 0) chk($sformatf("v%0d_latency", i), c, vecs[i].exp_cyc);
            chk($sformatf("v%0d_done_pulses", i), done_cnt - d0, 1);
            chk($sformatf("v%0d_idle_after", i), {busy_o, done_o}, 0);
            chk($sformatf("v%0d_polls", i), n_polls, vecs[i].exp_polls);
            chk($sformatf("v%0d_reads", i), n_reads, vecs[i].exp_reads);
            chk($sformatf("v%0d_sb_drained", i), exp_q.size(), 0);
            if (vecs[i].chk_gap) chk($sformatf("v%0d_poll_spacing", i), gap_bad, 0);
        end

        // Consumer stall on word 2.
        load_cfg(16, 0, 0, 32'hB000_0000);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'hB000_0000 + 32'(k));
        a0 = n_acc;
        start_blk(4);
        c = 0;
        while (!(out_vld_o && n_acc - a0 == 2) && c < 200) begin
            cyc1();
            c++;
        end
        chk("stall_reach_word2", c < 200, 1);
        out_rdy_i = 1'b0;
        hold = out_dat_o;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc1();
            if (!out_vld_o || out_dat_o !== hold || wbd_stb_o) bad++;
        end
        chk("stall_word2_value", hold, 32'hB000_0002);
        chk("stall_stable_no_read", bad, 0);
        out_rdy_i = 1'b1;
        wait_done(c);
        chk("stall_done", c < 4000, 1);
        chk("stall_reads", n_reads, 4);
        chk("stall_sb_drained", exp_q.size(), 0);

        // Abort while a data strobe waits for its ack.
        load_cfg(16, 0, 0, 32'hC000_0000);
        d_ack_en = 1'b0;
        d0 = done_cnt;
        v0 = vld_cnt;
        start_blk(4);
        c = 0;
        while (!wbd_stb_o && c < 50) begin
            cyc1();
            c++;
        end
        chk("abort_reach_stb", c < 50, 1);
        abort_i = 1'b1;
        cyc1();
        abort_i = 1'b0;
        cyc1();
        cyc1();
        chk("abort_holds_cycle", {busy_o, wbd_stb_o}, 2'b11);
        d_ack_en = 1'b1;
        cyc1();
        chk("abort_idle", {busy_o, wbd_cyc_o, wbd_stb_o, out_vld_o}, 0);
        cyc1();
        cyc1();
        chk("abort_reads", n_reads, 1);
        chk("abort_no_vld", vld_cnt - v0, 0);
        chk("abort_no_done", done_cnt - d0, 0);

        // A fresh block after the abort.
        load_cfg(16, 0, 0, 32'hD000_0000);
        for (int k = 0; k < 2; k++) exp_q.push_back(32'hD000_0000 + 32'(k));
        d0 = done_cnt;
        start_blk(2);
        wait_done(c);
        chk("restart_done", done_cnt - d0, 1);
        chk("restart_reads", n_reads, 2);
        chk("restart_sb_drained", exp_q.size(), 0);

        // Start together with abort in IDLE is ignored.
        d0 = done_cnt;
        len_i = LEN_W'(3);
        start_i = 1'b1;
        abort_i = 1'b1;
        cyc1();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", busy_o, 0);
        cyc1();
        chk("start_abort_no_done", done_cnt - d0, 0);

        // Reset in the middle of a burst.
        load_cfg(16, 0, 0, 32'hE000_0000);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'hE000_0000 + 32'(k));
        d0 = done_cnt;
        start_blk(8);
        c = 0;
        while (!(wbd_stb_o && n_reads >= 2) && c < 100) begin
            cyc1();
            c++;
        end
        chk("rst_reach_burst", c < 100, 1);
        rst_i = 1'b1;
        cyc1();
        chk("rst_ctrl_zero", {busy_o, done_o, wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o, out_vld_o}, 0);
        chk("rst_data_zero", out_dat_o, 0);
        rst_i = 1'b0;
        exp_q.delete();
        repeat (3) cyc1();
        chk("rst_stays_idle", busy_o, 0);
        chk("rst_no_done", done_cnt - d0, 0);

        chk("no_strobe_overlap", ovl_cnt, 0);
        chk("no_overread", overread, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
